// File: rtl/vmm_psum_collector_pkg.sv
// ---------------------------------------------------------------------------
// vmm_psum_collector_pkg
// Shared constants, FSM encoding and per-lane arithmetic for the systolic VMM
// partial-sum collector.
//
// Default widths come from the array-wide macros `Tout, `MAX_DW2 and
// `log2_Tin. Each macro gets a fallback value if the including build has not
// set it.
//
// Build option: PSUM_SAT_EN makes lane_add() saturate. When it is undefined,
// lane_add() wraps in two's complement.
// ---------------------------------------------------------------------------
`ifndef Tout
`define Tout 8
`endif
`ifndef MAX_DW2
`define MAX_DW2 16
`endif
`ifndef log2_Tin
`define log2_Tin 3
`endif

package vmm_psum_collector_pkg;

    localparam int TOUT_DEF  = `Tout;
    localparam int IN_W_DEF  = `MAX_DW2 + `log2_Tin;
    localparam int ACC_W_DEF = 32;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACC  = 1'b1
    } psum_state_e;

    // Adds two lane values that are already sign-extended to 64 bits. The
    // result is only meaningful in its low w bits (w <= 62).
    // - Saturating build: the result is clamped to the signed w-bit range.
    // - Default build: the result is folded back into w bits, which gives
    //   modulo-2^w wrap.
    function automatic logic signed [63:0] lane_add(
        input logic signed [63:0] a,
        input logic signed [63:0] b,
        input int unsigned        w
    );
        logic signed [63:0] sum;
`ifdef PSUM_SAT_EN
        logic signed [63:0] maxv;
        logic signed [63:0] minv;
`endif
        sum = a + b;
`ifdef PSUM_SAT_EN
        maxv = (64'sd1 <<< (w - 1)) - 64'sd1;
        minv = -(64'sd1 <<< (w - 1));
        if (sum > maxv) begin
            sum = maxv;
        end else if (sum < minv) begin
            sum = minv;
        end
`else
        sum = (sum <<< (64 - w)) >>> (64 - w);
`endif
        return sum;
    endfunction

endpackage

// File: rtl/vmm_psum_collector_if.sv
// ---------------------------------------------------------------------------
// vmm_psum_collector_if
// Stream bundle around the partial-sum collector.
//   i_vld/i_first/i_last/i_dat : deskewed partial-sum vector from the array
//   o_vld/o_rdy/o_dat          : completed output vectors, valid/ready drain
// Modports:
//   master : the side that drives the array stream and the downstream ready
//   slave  : the collector itself
// ---------------------------------------------------------------------------
interface vmm_psum_collector_if
    import vmm_psum_collector_pkg::*;
#(
    parameter int TOUT  = TOUT_DEF,
    parameter int IN_W  = IN_W_DEF,
    parameter int ACC_W = ACC_W_DEF
) ();

    logic                    i_vld;
    logic                    i_first;
    logic                    i_last;
    logic [IN_W*TOUT-1:0]    i_dat;
    logic                    o_vld;
    logic                    o_rdy;
    logic [ACC_W*TOUT-1:0]   o_dat;

    modport master (
        output i_vld, i_first, i_last, i_dat, o_rdy,
        input  o_vld, o_dat
    );

    modport slave (
        input  i_vld, i_first, i_last, i_dat, o_rdy,
        output o_vld, o_dat
    );

endinterface

// File: rtl/vmm_psum_collector_psum_fifo.sv
// ---------------------------------------------------------------------------
// vmm_psum_collector_psum_fifo
// Generic synchronous FIFO for output stages.
//   clk, rst_n   : clock and synchronous active-low reset
//   push_i       : write request. It is accepted when the FIFO is not full,
//                  or when it is full and a pop happens in the same cycle.
//   wdata_i      : write data
//   pop_i        : read request. It is ignored when the FIFO is empty.
//   rdata_o      : head entry. It reads as zero while the FIFO is empty.
//   count_next_o : occupancy after this cycle's push/pop (0..DEPTH)
//   full_o       : FIFO is full
//   empty_o      : FIFO is empty
// DEPTH must be a power of two, so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module vmm_psum_collector_psum_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           push_i,
    input  logic [WIDTH-1:0]               wdata_i,
    input  logic                           pop_i,
    output logic [WIDTH-1:0]               rdata_o,
    output logic [$clog2(DEPTH+1)-1:0]     count_next_o,
    output logic                           full_o,
    output logic                           empty_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);

    assign rdata_o      = empty_o ? '0 : mem_q[rd_ptr_q];
    assign count_next_o = count_d;

    // Occupancy bookkeeping. A push and a pop in the same cycle cancel out.
    always_comb begin
        count_d = count_q;
        if (push_ok && !pop_ok) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push_ok && pop_ok) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            count_q <= count_d;
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
        end
    end

    // Storage has no reset. Stale entries are hidden by the empty mask on
    // rdata_o.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/vmm_psum_collector.sv
// ---------------------------------------------------------------------------
// vmm_psum_collector
// Consumer end of the systolic VMM array. It accumulates Tout-lane partial
// sums over successive input-channel chunks and queues each completed vector
// in an output FIFO.
//
// Ports:
//   clk, rst_n : clock and synchronous active-low reset
//   bus        : vmm_psum_collector_if.slave
//                (input i_vld/i_first/i_last/i_dat; output o_vld/o_rdy/o_dat)
//   o_afull    : registered flag, FIFO occupancy >= DEPTH-AF_MARGIN
//   o_busy     : an accumulation is open
//   o_ovf_err  : sticky flag, a completed vector was dropped on a full FIFO
//   o_seq_err  : sticky flag, first/last protocol violation
//   i_clr_err  : clears both sticky flags. An error in the same cycle wins.
//
// Build option: PSUM_SAT_EN saturates the per-lane adds. When it is
// undefined, the adds wrap.
// ---------------------------------------------------------------------------
module vmm_psum_collector
    import vmm_psum_collector_pkg::*;
#(
    parameter int TOUT      = TOUT_DEF,
    parameter int IN_W      = IN_W_DEF,
    parameter int ACC_W     = ACC_W_DEF,
    parameter int DEPTH     = 4,
    parameter int AF_MARGIN = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    vmm_psum_collector_if.slave    bus,
    output logic                   o_afull,
    output logic                   o_busy,
    output logic                   o_ovf_err,
    output logic                   o_seq_err,
    input  logic                   i_clr_err
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    psum_state_e             state_q;
    psum_state_e             state_d;
    logic signed [ACC_W-1:0] acc_q    [TOUT];
    logic signed [ACC_W-1:0] acc_d    [TOUT];
    logic signed [ACC_W-1:0] lane_res [TOUT];
    logic [ACC_W*TOUT-1:0]   push_dat;
    logic                    start;
    logic                    push;
    logic                    pop;
    logic                    seq_evt;
    logic                    ovf_evt;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [CNT_W-1:0]        count_next;
    logic                    afull_q;
    logic                    ovf_err_q;
    logic                    seq_err_q;

    // A chunk begins a fresh vector when nothing is open, or when i_first
    // forces a restart. A restart discards whatever was accumulated.
    assign start = (state_q == ST_IDLE) || bus.i_first;

    // Per-lane datapath. A load is a plain sign extension and never
    // saturates. Only a true add goes through lane_add().
    for (genvar k = 0; k < TOUT; k++) begin : g_lane
        logic signed [IN_W-1:0]  in_lane;
        logic signed [ACC_W-1:0] in_sext;

        assign in_lane     = bus.i_dat[k*IN_W +: IN_W];
        assign in_sext     = ACC_W'(in_lane);
        assign lane_res[k] = start ? in_sext
                                   : ACC_W'(lane_add(64'(acc_q[k]), 64'(in_sext), ACC_W));
        assign push_dat[k*ACC_W +: ACC_W] = lane_res[k];
    end

    // FSM next state, accumulator update and the push request.
    // Nothing changes on a cycle without i_vld.
    always_comb begin
        state_d = state_q;
        push    = 1'b0;
        seq_evt = 1'b0;
        for (int k = 0; k < TOUT; k++) begin
            acc_d[k] = acc_q[k];
        end
        if (bus.i_vld) begin
            seq_evt = ((state_q == ST_IDLE) && !bus.i_first) ||
                      ((state_q == ST_ACC) && bus.i_first);
            if (bus.i_last) begin
                push    = 1'b1;
                state_d = ST_IDLE;
                for (int k = 0; k < TOUT; k++) begin
                    acc_d[k] = '0;
                end
            end else begin
                state_d = ST_ACC;
                for (int k = 0; k < TOUT; k++) begin
                    acc_d[k] = lane_res[k];
                end
            end
        end
    end

    // State and accumulator registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            for (int k = 0; k < TOUT; k++) begin
                acc_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            for (int k = 0; k < TOUT; k++) begin
                acc_q[k] <= acc_d[k];
            end
        end
    end

    assign pop     = !fifo_empty && bus.o_rdy;
    // A result is lost only when the FIFO is full and nothing leaves this cycle
    assign ovf_evt = push && fifo_full && !pop;

    vmm_psum_collector_psum_fifo #(
        .WIDTH (ACC_W * TOUT),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .push_i       (push),
        .wdata_i      (push_dat),
        .pop_i        (pop),
        .rdata_o      (bus.o_dat),
        .count_next_o (count_next),
        .full_o       (fifo_full),
        .empty_o      (fifo_empty)
    );

    // Almost-full flag and sticky errors. o_afull follows the next-state
    // occupancy, so the scheduler sees it one cycle after the push or pop
    // that caused it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            afull_q   <= 1'b0;
            ovf_err_q <= 1'b0;
            seq_err_q <= 1'b0;
        end else begin
            afull_q <= (count_next >= CNT_W'(DEPTH - AF_MARGIN));
            if (ovf_evt) begin
                ovf_err_q <= 1'b1;
            end else if (i_clr_err) begin
                ovf_err_q <= 1'b0;
            end
            if (seq_evt) begin
                seq_err_q <= 1'b1;
            end else if (i_clr_err) begin
                seq_err_q <= 1'b0;
            end
        end
    end

    assign bus.o_vld = !fifo_empty;
    assign o_afull   = afull_q;
    assign o_busy    = (state_q == ST_ACC);
    assign o_ovf_err = ovf_err_q;
    assign o_seq_err = seq_err_q;

endmodule
